// File: rtl/tawas_rcn_arb_if.sv
// ---------------------------------------------------------------------------
// tawas_rcn_arb_if
//
// Bundles every bus signal around the two-port RCN issue arbiter:
//   - requester port A (a_*) and requester port B (b_*):
//       req/seq/wr/mask/addr/wdata toward the arbiter,
//       ack/rdone/wdone back to the requester
//   - master buffer side (m_*):
//       cs/seq/wr/mask/addr/wdata issued by the arbiter,
//       full/rdone/wdone/rsp_seq returned by the buffer
//
// Handshake: a requester raises X_req with stable fields and holds them
// until the cycle in which X_ack is high; that cycle is the transfer.
//
// Modports:
//   slave  - the arbiter's view (receives requests and buffer responses)
//   master - the view of whatever drives requests and models the buffer
// ---------------------------------------------------------------------------
interface tawas_rcn_arb_if;
   logic        a_req;
   logic [4:0]  a_seq;
   logic        a_wr;
   logic [3:0]  a_mask;
   logic [23:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_ack;
   logic        a_rdone;
   logic        a_wdone;

   logic        b_req;
   logic [4:0]  b_seq;
   logic        b_wr;
   logic [3:0]  b_mask;
   logic [23:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_ack;
   logic        b_rdone;
   logic        b_wdone;

   logic        m_cs;
   logic [4:0]  m_seq;
   logic        m_wr;
   logic [3:0]  m_mask;
   logic [23:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_full;
   logic        m_rdone;
   logic        m_wdone;
   logic [4:0]  m_rsp_seq;

   modport slave (
      input  a_req, a_seq, a_wr, a_mask, a_addr, a_wdata,
      output a_ack, a_rdone, a_wdone,
      input  b_req, b_seq, b_wr, b_mask, b_addr, b_wdata,
      output b_ack, b_rdone, b_wdone,
      output m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata,
      input  m_full, m_rdone, m_wdone, m_rsp_seq
   );

   modport master (
      output a_req, a_seq, a_wr, a_mask, a_addr, a_wdata,
      input  a_ack, a_rdone, a_wdone,
      output b_req, b_seq, b_wr, b_mask, b_addr, b_wdata,
      input  b_ack, b_rdone, b_wdone,
      input  m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata,
      output m_full, m_rdone, m_wdone, m_rsp_seq
   );
endinterface

// File: rtl/tawas_rcn_arb.sv
// ---------------------------------------------------------------------------
// tawas_rcn_arb
//
// Shares one RCN master issue interface between the core load/store unit
// (port A) and a secondary requester (port B). A 32-entry busy/owner
// scoreboard indexed by the 5-bit seq tag keeps any tag from being
// outstanding twice and routes each response back to the issuing port.
//
// Parameters:
//   PRIORITY_A  - 1: A always wins a tie; 0: alternate between A and B
//   MAX_PENDING - per-port outstanding limit (1..32)
//
// Ports:
//   clk, rst   - clock; asynchronous active-high reset
//   bus        - tawas_rcn_arb_if.slave (ports A/B and master buffer side)
//   busy       - scoreboard, bit s set while tag s is outstanding
//   a_pending  - outstanding transaction count of port A
//   b_pending  - outstanding transaction count of port B
//   stray_rsp  - one-cycle flag: response for a tag that is not busy
//   prefer_a   - tie-break state: 1 when A wins the next contested grant
// ---------------------------------------------------------------------------
module tawas_rcn_arb #(
   parameter bit PRIORITY_A  = 1'b0,
   parameter int MAX_PENDING = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   tawas_rcn_arb_if.slave       bus,
   output logic [31:0]          busy,
   output logic [5:0]           a_pending,
   output logic [5:0]           b_pending,
   output logic                 stray_rsp,
   output logic                 prefer_a
);

   localparam logic [5:0] MAX_P = 6'(MAX_PENDING);

   logic [31:0] owner;          // 0 = port A, 1 = port B
   logic [31:0] busy_nxt;
   logic [31:0] owner_nxt;
   logic        elig_a;
   logic        elig_b;
   logic        grant_a;
   logic        grant_b;
   logic        rsp_v;
   logic        rsp_hit;
   logic        rsp_to_b;
   logic        dec_a;
   logic        dec_b;

   // Eligibility looks at the registered scoreboard only, so a tag being
   // cleared this cycle can not be re-granted until the next cycle.
   assign elig_a = bus.a_req && !busy[bus.a_seq] && (a_pending < MAX_P) && !bus.m_full;
   assign elig_b = bus.b_req && !busy[bus.b_seq] && (b_pending < MAX_P) && !bus.m_full;

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (elig_a && (!elig_b || PRIORITY_A || prefer_a)) begin
         grant_a = 1'b1;
      end else if (elig_b) begin
         grant_b = 1'b1;
      end
   end

   assign bus.a_ack = grant_a;
   assign bus.b_ack = grant_b;

   // Response routing: only a busy tag is delivered, to the port that owns it.
   assign rsp_v    = bus.m_rdone || bus.m_wdone;
   assign rsp_hit  = rsp_v && busy[bus.m_rsp_seq];
   assign rsp_to_b = owner[bus.m_rsp_seq];
   assign dec_a    = rsp_hit && !rsp_to_b;
   assign dec_b    = rsp_hit && rsp_to_b;

   assign bus.a_rdone = dec_a && bus.m_rdone;
   assign bus.a_wdone = dec_a && bus.m_wdone;
   assign bus.b_rdone = dec_b && bus.m_rdone;
   assign bus.b_wdone = dec_b && bus.m_wdone;
   assign stray_rsp   = rsp_v && !busy[bus.m_rsp_seq];

   // A granted tag is never busy and a cleared tag always is, so the set
   // and the clear below never hit the same bit.
   always_comb begin
      busy_nxt  = busy;
      owner_nxt = owner;
      if (rsp_hit) begin
         busy_nxt[bus.m_rsp_seq] = 1'b0;
      end
      if (grant_a) begin
         busy_nxt[bus.a_seq]  = 1'b1;
         owner_nxt[bus.a_seq] = 1'b0;
      end
      if (grant_b) begin
         busy_nxt[bus.b_seq]  = 1'b1;
         owner_nxt[bus.b_seq] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= '0;
         owner     <= '0;
         a_pending <= '0;
         b_pending <= '0;
         prefer_a  <= 1'b1;
      end else begin
         busy  <= busy_nxt;
         owner <= owner_nxt;
         case ({grant_a, dec_a})
            2'b10:   a_pending <= a_pending + 6'd1;
            2'b01:   a_pending <= a_pending - 6'd1;
            default: a_pending <= a_pending;
         endcase
         case ({grant_b, dec_b})
            2'b10:   b_pending <= b_pending + 6'd1;
            2'b01:   b_pending <= b_pending - 6'd1;
            default: b_pending <= b_pending;
         endcase
         // After a grant the other port wins the next tie.
         if (grant_a || grant_b) begin
            prefer_a <= grant_b;
         end
      end
   end

   // Issue register: strobe every cycle, data fields only on a grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.m_cs    <= 1'b0;
         bus.m_seq   <= '0;
         bus.m_wr    <= 1'b0;
         bus.m_mask  <= '0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
      end else begin
         bus.m_cs <= grant_a || grant_b;
         if (grant_a) begin
            bus.m_seq   <= bus.a_seq;
            bus.m_wr    <= bus.a_wr;
            bus.m_mask  <= bus.a_mask;
            bus.m_addr  <= bus.a_addr;
            bus.m_wdata <= bus.a_wdata;
         end else if (grant_b) begin
            bus.m_seq   <= bus.b_seq;
            bus.m_wr    <= bus.b_wr;
            bus.m_mask  <= bus.b_mask;
            bus.m_addr  <= bus.b_addr;
            bus.m_wdata <= bus.b_wdata;
         end
      end
   end

endmodule

// File: tb/tb_tawas_rcn_arb.sv
// ---------------------------------------------------------------------------
// tb_tawas_rcn_arb
//
// Three arbiter instances share one stimulus set; sel picks which one
// receives requests/responses and which one is observed:
//   0: PRIORITY_A=0, MAX_PENDING=32
//   1: PRIORITY_A=1, MAX_PENDING=32
//   2: PRIORITY_A=0, MAX_PENDING=2
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_tawas_rcn_arb;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   int          sel = 0;
   logic        ar = 1'b0, aw = 1'b0, br = 1'b0, bw = 1'b0;
   logic [4:0]  as = '0, bs = '0, rs = '0;
   logic [23:0] aa = '0, ba = '0;
   logic        full = 1'b0, rd = 1'b0, wd = 1'b0;

   // ---------------- observation ----------------
   logic [72:0] obs_v     [3];
   logic [31:0] busy_v    [3];
   logic [5:0]  apend_v   [3];
   logic [5:0]  bpend_v   [3];
   logic        stray_v   [3];
   logic        prefer_v  [3];

   logic        o_a_ack, o_b_ack, o_a_rdone, o_a_wdone, o_b_rdone, o_b_wdone;
   logic        o_m_cs, o_m_wr;
   logic [4:0]  o_m_seq;
   logic [3:0]  o_m_mask;
   logic [23:0] o_m_addr;
   logic [31:0] o_m_wdata;
   logic [31:0] o_busy;
   logic [5:0]  o_apend, o_bpend;
   logic        o_stray;

   assign {o_a_ack, o_b_ack, o_a_rdone, o_a_wdone, o_b_rdone, o_b_wdone,
           o_m_cs, o_m_seq, o_m_wr, o_m_mask, o_m_addr, o_m_wdata} = obs_v[sel];
   assign o_busy  = busy_v[sel];
   assign o_apend = apend_v[sel];
   assign o_bpend = bpend_v[sel];
   assign o_stray = stray_v[sel];

   for (genvar k = 0; k < 3; k++) begin : g
      tawas_rcn_arb_if bus ();

      assign bus.a_req     = (sel == k) && ar;
      assign bus.a_seq     = as;
      assign bus.a_wr      = aw;
      assign bus.a_mask    = 4'hF;
      assign bus.a_addr    = aa;
      assign bus.a_wdata   = {8'hA5, aa};
      assign bus.b_req     = (sel == k) && br;
      assign bus.b_seq     = bs;
      assign bus.b_wr      = bw;
      assign bus.b_mask    = 4'h3;
      assign bus.b_addr    = ba;
      assign bus.b_wdata   = {8'hB6, ba};
      assign bus.m_full    = (sel == k) && full;
      assign bus.m_rdone   = (sel == k) && rd;
      assign bus.m_wdone   = (sel == k) && wd;
      assign bus.m_rsp_seq = rs;

      assign obs_v[k] = {bus.a_ack, bus.b_ack, bus.a_rdone, bus.a_wdone,
                         bus.b_rdone, bus.b_wdone, bus.m_cs, bus.m_seq,
                         bus.m_wr, bus.m_mask, bus.m_addr, bus.m_wdata};

      tawas_rcn_arb #(
         .PRIORITY_A  (k == 1),
         .MAX_PENDING ((k == 2) ? 2 : 32)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .bus       (bus),
         .busy      (busy_v[k]),
         .a_pending (apend_v[k]),
         .b_pending (bpend_v[k]),
         .stray_rsp (stray_v[k]),
         .prefer_a  (prefer_v[k])
      );
   end

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [0:0] exp_q[$];          // expected grant order, 0 = A, 1 = B

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      adv();
      adv();
      rst = 1'b0;
   endtask

   // Both ports request continuously, A with tags 0..3, B with 16..19; the
   // grant order is compared against exp_q, then every tag is answered and
   // the response must come back on the issuing port.
   task automatic run_pair(input string tname);
      int       ia = 0;
      int       ib = 0;
      int       cyc = 0;
      logic     ga, gb;
      logic [0:0] e;
      ar = 1'b1; as = 5'd0; br = 1'b1; bs = 5'd16;
      while ((ia < 4 || ib < 4) && cyc < 20) begin
         settle();
         ga = o_a_ack;
         gb = o_b_ack;
         if (ga || gb) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            check({tname, "_order"}, {62'd0, ga, gb}, e ? 64'd1 : 64'd2);
         end
         adv();
         if (ga) begin
            ia++;
            as = 5'(ia);
            if (ia == 4) ar = 1'b0;
         end
         if (gb) begin
            ib++;
            bs = 5'(16 + ib);
            if (ib == 4) br = 1'b0;
         end
         cyc++;
      end
      ar = 1'b0; br = 1'b0;
      check({tname, "_grants"}, {ia, ib}, {32'd4, 32'd4});
      for (int i = 0; i < 8; i++) begin
         rd = 1'b1;
         rs = (i < 4) ? 5'(i) : 5'(16 + i - 4);
         settle();
         check({tname, "_route"}, {62'd0, o_a_rdone, o_b_rdone}, (i < 4) ? 64'd2 : 64'd1);
         adv();
      end
      rd = 1'b0;
      settle();
      check({tname, "_drained"}, {o_busy, 20'd0, o_apend, o_bpend}, 64'd0);
      adv();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      do_reset();
      settle();
      check("rst_busy",   64'(o_busy), 64'd0);
      check("rst_pend",   {o_apend, o_bpend}, 64'd0);
      check("rst_m_cs",   64'(o_m_cs), 64'd0);
      check("rst_m_data", {o_m_seq, o_m_wr, o_m_mask, o_m_addr}, 64'd0);
      check("rst_wdata",  64'(o_m_wdata), 64'd0);
      check("rst_flags",  {o_a_ack, o_b_ack, o_a_rdone, o_a_wdone, o_b_rdone, o_b_wdone, o_stray}, 64'd0);

      // ---- single read on A ----
      adv();
      ar = 1'b1; as = 5'd5; aw = 1'b0; aa = 24'h001000;
      settle();
      check("t1_ack", {o_a_ack, o_b_ack}, 64'd2);
      adv();
      ar = 1'b0;
      settle();
      check("t1_m_cs",    64'(o_m_cs), 64'd1);
      check("t1_m_fields", {o_m_seq, o_m_wr, o_m_mask, o_m_addr}, {5'd5, 1'b0, 4'hF, 24'h001000});
      check("t1_m_wdata", 64'(o_m_wdata), 64'hA500_1000);
      check("t1_busy",    64'(o_busy), 64'h20);
      check("t1_apend",   64'(o_apend), 64'd1);
      adv();
      rd = 1'b1; rs = 5'd5;
      settle();
      check("t1_m_cs_off", 64'(o_m_cs), 64'd0);
      check("t1_done", {o_a_rdone, o_a_wdone, o_b_rdone, o_b_wdone, o_stray}, 64'b10000);
      adv();
      rd = 1'b0;
      settle();
      check("t1_cleared", {o_busy, o_apend}, 64'd0);
      check("t1_hold_addr", 64'(o_m_addr), 64'h001000);

      // ---- round robin, then fixed priority ----
      adv();
      do_reset();
      exp_q = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      run_pair("t2_rr");
      sel = 1;
      exp_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      run_pair("t2_pri");
      sel = 0;

      // ---- tag collision ----
      ar = 1'b1; as = 5'd7; aw = 1'b1; aa = 24'h00_2000;
      settle();
      check("t3_a_ack", 64'(o_a_ack), 64'd1);
      adv();
      ar = 1'b0; aw = 1'b0;
      br = 1'b1; bs = 5'd7; ba = 24'h00_3000;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("t3_b_blocked", 64'(o_b_ack), 64'd0);
         adv();
      end
      wd = 1'b1; rs = 5'd7;
      settle();
      check("t3_wdone", {o_a_rdone, o_a_wdone, o_b_rdone, o_b_wdone}, 64'b0100);
      check("t3_b_still_blocked", 64'(o_b_ack), 64'd0);
      adv();
      wd = 1'b0;
      settle();
      check("t3_b_ack", {o_busy, o_b_ack}, 64'd1);
      adv();
      br = 1'b0;
      settle();
      check("t3_b_owner_state", {o_busy, 20'd0, o_apend, o_bpend}, {32'h80, 20'd0, 6'd0, 6'd1});
      check("t3_m_seq", {o_m_cs, o_m_seq, o_m_addr}, {1'b1, 5'd7, 24'h00_3000});
      adv();
      rd = 1'b1; rs = 5'd7;
      settle();
      check("t3_route_b", {o_a_rdone, o_b_rdone}, 64'd1);
      adv();
      rd = 1'b0;

      // ---- backpressure ----
      full = 1'b1;
      ar = 1'b1; as = 5'd8; aa = 24'h00_0800;
      br = 1'b1; bs = 5'd9; ba = 24'h00_0900;
      for (int i = 0; i < 10; i++) begin
         settle();
         check("t4_full_block", {o_a_ack, o_b_ack, o_m_cs}, 64'd0);
         adv();
      end
      full = 1'b0;
      settle();
      check("t4_release_ack", {o_a_ack, o_b_ack}, 64'd2);
      adv();
      full = 1'b1; ar = 1'b0;
      settle();
      check("t4_issue_under_full", {o_m_cs, o_m_seq, o_b_ack}, {1'b1, 5'd8, 1'b0});
      adv();
      full = 1'b0;
      settle();
      check("t4_b_ack", {o_b_ack, o_m_cs}, 64'd2);
      adv();
      br = 1'b0;
      settle();
      check("t4_b_issue", {o_m_cs, o_m_seq, o_m_mask}, {1'b1, 5'd9, 4'h3});
      check("t4_state", {o_busy, 20'd0, o_apend, o_bpend}, {32'h300, 20'd0, 6'd1, 6'd1});

      // ---- stray response and reset ----
      adv();
      rd = 1'b1; rs = 5'd12;
      settle();
      check("t5_stray", {o_stray, o_a_rdone, o_a_wdone, o_b_rdone, o_b_wdone}, 64'b10000);
      adv();
      rd = 1'b0;
      settle();
      check("t5_unchanged", {o_busy, o_stray}, {32'h300, 1'b0});
      adv();
      ar = 1'b1; as = 5'd10;
      settle();
      check("t5_a_ack", 64'(o_a_ack), 64'd1);
      adv();
      ar = 1'b0;
      settle();
      check("t5_three_out", {o_busy, 20'd0, o_apend, o_bpend}, {32'h700, 20'd0, 6'd2, 6'd1});
      rst = 1'b1;
      #1;
      check("t5_async_rst", {o_busy, 20'd0, o_apend, o_bpend}, 64'd0);
      check("t5_rst_m_cs", 64'(o_m_cs), 64'd0);
      adv();
      adv();
      rst = 1'b0;
      for (int t = 8; t <= 10; t++) begin
         rd = 1'b1; rs = 5'(t);
         settle();
         check("t5_post_rst_stray", {o_stray, o_a_rdone, o_b_rdone}, 64'b100);
         adv();
      end
      rd = 1'b0;

      // ---- per-port limit ----
      sel = 2;
      ar = 1'b1; as = 5'd1;
      settle();
      check("t6_a1", 64'(o_a_ack), 64'd1);
      adv();
      as = 5'd2;
      settle();
      check("t6_a2", 64'(o_a_ack), 64'd1);
      adv();
      as = 5'd3; br = 1'b1; bs = 5'd20;
      settle();
      check("t6_limit", {o_a_ack, o_b_ack, 2'b00, o_apend}, {1'b0, 1'b1, 2'b00, 6'd2});
      adv();
      br = 1'b0;
      settle();
      check("t6_wait", {o_a_ack, 1'b0, o_apend, o_bpend}, {1'b0, 1'b0, 6'd2, 6'd1});
      adv();
      rd = 1'b1; rs = 5'd1;
      settle();
      check("t6_rsp", {o_a_rdone, o_a_ack}, 64'd2);
      adv();
      rd = 1'b0;
      settle();
      check("t6_regrant", {o_a_ack, 1'b0, o_apend}, {1'b1, 1'b0, 6'd1});
      adv();
      ar = 1'b0;
      settle();
      check("t6_final", {o_busy, 26'd0, o_apend}, {32'h0010_000C, 26'd0, 6'd2});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tawas_rcn_arb.md
Name: tawas_rcn_arb

Overview:
Two-port arbiter that shares one RCN master issue interface between the core load/store unit (port A) and a secondary requester such as a debug or DMA engine (port B). Each transaction carries a 5-bit seq tag. The block keeps a 32-entry busy/owner scoreboard so the same tag is never outstanding twice, and routes each response back to the port that issued it. It sits between the requesters and the RCN master buffer.

Parameters:
PRIORITY_A, 0, 1 = port A has fixed priority over B; 0 = round-robin between the two ports.
MAX_PENDING, 32, per-port limit on outstanding transactions (1..32); a port at its limit is not eligible for grant.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
a_req  in  1  port A request; held until a_ack
a_seq  in  5  port A transaction tag
a_wr  in  1  port A write (1) / read (0)
a_mask  in  4  port A byte mask
a_addr  in  24  port A address
a_wdata  in  32  port A write data
a_ack  out  1  port A grant; combinational, same cycle as the grant decision
b_req, b_seq, b_wr, b_mask, b_addr, b_wdata, b_ack  as for port A
m_cs  out  1  issue strobe to master buffer (registered)
m_seq  out  5  issued tag (registered)
m_wr  out  1  issued write flag (registered)
m_mask  out  4  issued byte mask (registered)
m_addr  out  24  issued address (registered)
m_wdata  out  32  issued write data (registered)
m_full  in  1  master buffer full; blocks all grants
m_rdone  in  1  read response valid
m_wdone  in  1  write response valid
m_rsp_seq  in  5  response tag
a_rdone, a_wdone  out  1 each  response qualified for port A
b_rdone, b_wdone  out  1 each  response qualified for port B
busy  out  32  scoreboard: bit s set = tag s is outstanding
a_pending  out  6  outstanding count for port A
b_pending  out  6  outstanding count for port B
stray_rsp  out  1  pulse: response arrived for a tag that is not busy

Behaviour:
- Reset values:
  - busy, owner and counts are 0.
  - m_cs is 0; m_seq, m_wr, m_mask, m_addr and m_wdata are 0.
  - Round-robin pointer favours A.
  - All ack, done and stray outputs are 0.
- Eligibility of port X: X_req && !busy[X_seq] && X_pending < MAX_PENDING && !m_full. busy is the registered value, not bypassed.
- Grant selection:
  - Only one port is eligible: grant it.
  - Both are eligible and PRIORITY_A=1: grant A.
  - Both are eligible and PRIORITY_A=0: grant the port not granted last. The pointer updates only on a grant.
  - a_seq == b_seq in the same cycle: only the selected port is granted. The other retries next cycle and finds busy set.
- Issue timing:
  - Grant in cycle N: X_ack=1 in N.
  - In N+1: m_cs=1 and m_* carry the captured X fields.
  - No grant in N: m_cs=0 in N+1; the m_* data fields hold their previous values.
- Scoreboard set: on grant of tag s, in N+1 busy[s]=1, owner[s]=granted port (0=A, 1=B), and that port's pending count is incremented.
- Response handling (m_rdone|m_wdone) with tag r, all combinational routing:
  - busy[r]=1: route to owner[r]. X_rdone=m_rdone and X_wdone=m_wdone for that port only.
  - Next cycle: busy[r]=0 and the owner port's pending count is decremented.
  - busy[r]=0: no port done signal fires, stray_rsp=1 for that cycle, and state is unchanged.
- Same-cycle grant and response:
  - Grant and response on different tags are both applied.
  - A pending count may increment and decrement in the same cycle; it nets to unchanged.
  - Grant of tag r while r is being cleared cannot occur, because eligibility uses the registered busy.
- m_full is sampled in the grant cycle only. An already-granted transaction is still issued in N+1 even if m_full rises; the master buffer absorbs one beat.
- Reset mid-operation clears all state. Responses that arrive after reset for pre-reset tags are reported as stray_rsp and dropped.
- Counts never exceed MAX_PENDING and never wrap.

Test Plan:
1. A single read: a_req, a_seq=5, a_wr=0, a_addr=0x001000 → a_ack in cycle N; m_cs=1, m_seq=5, m_addr=0x001000 in N+1; busy[5]=1, a_pending=1. Then m_rdone with m_rsp_seq=5 → a_rdone=1, b_rdone=0; busy[5]=0 and a_pending=0 the next cycle.
2. Round-robin (PRIORITY_A=0): both ports request continuously with distinct tags (A tags 0..3, B tags 16..19) → grants alternate A, B, A, B, … starting with A after reset. With PRIORITY_A=1 → four consecutive A grants before any B grant.
3. Tag collision: A issues tag 7; while it is busy, B requests tag 7 → b_ack stays 0. Write response for tag 7 → a_wdone=1. B is granted one cycle after busy[7] clears, with owner[7]=B.
4. Backpressure: m_full=1 for 10 cycles with both ports requesting → no ack and no m_cs. m_full falls → grant in the same cycle, m_cs on the next cycle.
5. Stray response and reset: m_rdone with m_rsp_seq=12 and busy[12]=0 → stray_rsp=1 and no port done. Then assert rst with 3 outstanding tags → busy=0, pending=0; post-reset responses for those tags give stray_rsp.
6. Limit: MAX_PENDING=2, A issues tags 1 and 2 → a third A request waits, a concurrent B request is granted. A is granted again the cycle after a response drops a_pending to 1.
